// File: rtl/snake_pkg.sv
// Shared snake game definitions: screen size, maze walls, food FSM states.
package snake_pkg;

    localparam int unsigned SCREEN_W   = 640;
    localparam int unsigned SCREEN_H   = 480;
    localparam int unsigned SNAKE_STEP = 3;

    localparam logic [9:0]  FALLBACK_X = 10'd300;
    localparam logic [9:0]  FALLBACK_Y = 10'd100;

    localparam logic [15:0] LFSR_MASK  = 16'hB400;

    // Wall rectangle, all bounds inclusive, 11-bit so box ends never wrap.
    typedef struct packed {
        logic [10:0] x0;
        logic [10:0] x1;
        logic [10:0] y0;
        logic [10:0] y1;
    } wall_t;

    localparam int NUM_WALLS = 21;

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_EAT    = 2'd1,
        ST_PLACE  = 2'd2
    } food_state_t;

    function automatic wall_t wall_at(input int idx);
        wall_t w;
        case (idx)
            0:  w = '{11'd0,   11'd20,  11'd0,   11'd120};
            1:  w = '{11'd0,   11'd20,  11'd360, 11'd480};
            2:  w = '{11'd620, 11'd640, 11'd0,   11'd120};
            3:  w = '{11'd620, 11'd640, 11'd360, 11'd480};
            4:  w = '{11'd20,  11'd240, 11'd0,   11'd20};
            5:  w = '{11'd400, 11'd620, 11'd0,   11'd20};
            6:  w = '{11'd20,  11'd240, 11'd460, 11'd480};
            7:  w = '{11'd400, 11'd620, 11'd460, 11'd480};
            8:  w = '{11'd160, 11'd180, 11'd180, 11'd300};
            9:  w = '{11'd220, 11'd240, 11'd180, 11'd300};
            10: w = '{11'd320, 11'd340, 11'd180, 11'd300};
            11: w = '{11'd420, 11'd440, 11'd180, 11'd300};
            12: w = '{11'd240, 11'd280, 11'd180, 11'd200};
            13: w = '{11'd240, 11'd280, 11'd230, 11'd250};
            14: w = '{11'd240, 11'd280, 11'd280, 11'd300};
            15: w = '{11'd340, 11'd380, 11'd180, 11'd200};
            16: w = '{11'd340, 11'd380, 11'd230, 11'd250};
            17: w = '{11'd340, 11'd380, 11'd280, 11'd300};
            18: w = '{11'd440, 11'd480, 11'd180, 11'd200};
            19: w = '{11'd440, 11'd480, 11'd230, 11'd250};
            default: w = '{11'd440, 11'd480, 11'd280, 11'd300};
        endcase
        return w;
    endfunction

    // One step of the 16-bit Galois LFSR; a non-zero state never maps to zero.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
    endfunction

endpackage

// File: rtl/maze_map.sv
// Combinational maze lookup: is a square box touching any wall rectangle?
module maze_map
    import snake_pkg::*;
(
    input  logic [9:0] box_x,
    input  logic [9:0] box_y,
    input  logic [9:0] box_size,
    output logic       blocked
);

    logic [10:0] bx;
    logic [10:0] by;
    logic [10:0] bx_end;
    logic [10:0] by_end;
    wall_t       w;

    assign bx     = {1'b0, box_x};
    assign by     = {1'b0, box_y};
    assign bx_end = bx + {1'b0, box_size};
    assign by_end = by + {1'b0, box_size};

    // Box covers [x, x+size) x [y, y+size); flag overlap with any inclusive wall.
    always_comb begin
        blocked = 1'b0;
        w       = '0;
        for (int i = 0; i < NUM_WALLS; i++) begin
            w = wall_at(i);
            if ((bx <= w.x1) && (bx_end > w.x0) && (by <= w.y1) && (by_end > w.y0))
                blocked = 1'b1;
        end
    end

endmodule

// File: rtl/food_controller.sv
// Snake food owner: hit detection, eat pulse, growth/score, LFSR placement.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_ACTIVE | food drawn; a head hit with run=1 moves to ST_EAT
// ST_EAT    | single cycle, eat=1; length/score already bumped
// ST_PLACE  | one LFSR candidate per run cycle, fallback after MAX_TRIES
module food_controller
    import snake_pkg::*;
#(
    parameter int unsigned FOOD_SIZE = 10,
    parameter int unsigned INIT_LEN  = 2,
    parameter int unsigned MAX_LEN   = 99,
    parameter int unsigned MAX_TRIES = 8,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    input  logic [9:0]  head_x,
    input  logic [9:0]  head_y,
    output logic [9:0]  food_x,
    output logic [9:0]  food_y,
    output logic        food_valid,
    output logic        eat,
    output logic [9:0]  length,
    output logic [13:0] score
);

    localparam int          TRIES_W   = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [TRIES_W-1:0] LAST_TRY = TRIES_W'(MAX_TRIES - 1);
    localparam logic [9:0]  SIZE10    = 10'(FOOD_SIZE);
    localparam logic [10:0] SIZE11    = 11'(FOOD_SIZE);
    localparam logic [9:0]  LEN_MAX   = 10'(MAX_LEN);
    localparam logic [13:0] SCORE_MAX = 14'h3FFF;

    food_state_t        state_q, state_d;
    logic [TRIES_W-1:0] tries_q, tries_d;
    logic [15:0]        lfsr_q;
    logic [9:0]         food_x_d, food_y_d, length_d;
    logic [13:0]        score_d;
    logic               food_valid_d, eat_d;

    logic [9:0]  cand_x, cand_y;
    logic [10:0] cx, cy, hx, hy, fx, fy;
    logic        cand_blocked, cand_in_bounds, cand_has_head, cand_ok, hit;

    assign cand_x = lfsr_q[9:0];
    assign cand_y = {1'b0, lfsr_q[15:7]};
    assign cx     = {1'b0, cand_x};
    assign cy     = {1'b0, cand_y};
    assign hx     = {1'b0, head_x};
    assign hy     = {1'b0, head_y};
    assign fx     = {1'b0, food_x};
    assign fy     = {1'b0, food_y};

    maze_map u_maze (
        .box_x    (cand_x),
        .box_y    (cand_y),
        .box_size (SIZE10),
        .blocked  (cand_blocked)
    );

    assign cand_in_bounds = (cx + SIZE11 <= 11'(SCREEN_W)) && (cy + SIZE11 <= 11'(SCREEN_H));
    assign cand_has_head  = (hx >= cx) && (hx < cx + SIZE11) && (hy >= cy) && (hy < cy + SIZE11);
    assign cand_ok        = cand_in_bounds && !cand_blocked && !cand_has_head;
    assign hit            = (hx >= fx) && (hx < fx + SIZE11) && (hy >= fy) && (hy < fy + SIZE11);

    // Free-running LFSR, deliberately independent of run and FSM state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) lfsr_q <= LFSR_SEED;
        else        lfsr_q <= lfsr_step(lfsr_q);
    end

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        state_d      = state_q;
        tries_d      = tries_q;
        food_x_d     = food_x;
        food_y_d     = food_y;
        food_valid_d = food_valid;
        eat_d        = 1'b0;
        length_d     = length;
        score_d      = score;
        case (state_q)
            ST_ACTIVE: begin
                if (run && hit) begin
                    state_d      = ST_EAT;
                    eat_d        = 1'b1;
                    food_valid_d = 1'b0;
                    length_d     = (length >= LEN_MAX) ? LEN_MAX : length + 10'd1;
                    score_d      = (score == SCORE_MAX) ? score : score + 14'd1;
                end
            end
            ST_EAT: begin
                // The eat pulse is a single cycle even if run drops here.
                tries_d = '0;
                state_d = ST_PLACE;
            end
            ST_PLACE: begin
                if (run) begin
                    if (cand_ok) begin
                        food_x_d     = cand_x;
                        food_y_d     = cand_y;
                        food_valid_d = 1'b1;
                        state_d      = ST_ACTIVE;
                    end else if (tries_q == LAST_TRY) begin
                        food_x_d     = FALLBACK_X;
                        food_y_d     = FALLBACK_Y;
                        food_valid_d = 1'b1;
                        state_d      = ST_ACTIVE;
                    end else begin
                        tries_d = tries_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_ACTIVE;
        endcase
    end

    // State and output registers; reset abandons any placement in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_ACTIVE;
            tries_q    <= '0;
            food_x     <= FALLBACK_X;
            food_y     <= FALLBACK_Y;
            food_valid <= 1'b1;
            eat        <= 1'b0;
            length     <= 10'(INIT_LEN);
            score      <= '0;
        end else begin
            state_q    <= state_d;
            tries_q    <= tries_d;
            food_x     <= food_x_d;
            food_y     <= food_y_d;
            food_valid <= food_valid_d;
            eat        <= eat_d;
            length     <= length_d;
            score      <= score_d;
        end
    end

endmodule

// File: tb/tb_food_controller.sv
// Directed bench for food_controller: reset, eat/grow, placement, fallback,
// saturation, run gating and asynchronous reset during placement.
module tb_food_controller;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        run   = 1'b0;
    logic [9:0]  head_x, head_y, head2_x, head2_y;
    logic [9:0]  food_x, food_y, length, food2_x, food2_y, length2;
    logic [13:0] score, score2;
    logic        food_valid, eat, food2_valid, eat2;

    int n_checks = 0;
    int n_errors = 0;
    int score_exp;
    int len_exp;
    bit found;

    // Independent copy of the maze wall list: x0, x1, y0, y1 inclusive.
    int walls [21][4] = '{
        '{0, 20, 0, 120},     '{0, 20, 360, 480},   '{620, 640, 0, 120},  '{620, 640, 360, 480},
        '{20, 240, 0, 20},    '{400, 620, 0, 20},   '{20, 240, 460, 480}, '{400, 620, 460, 480},
        '{160, 180, 180, 300}, '{220, 240, 180, 300}, '{320, 340, 180, 300}, '{420, 440, 180, 300},
        '{240, 280, 180, 200}, '{240, 280, 230, 250}, '{240, 280, 280, 300},
        '{340, 380, 180, 200}, '{340, 380, 230, 250}, '{340, 380, 280, 300},
        '{440, 480, 180, 200}, '{440, 480, 230, 250}, '{440, 480, 280, 300}
    };

    always #5 clock = ~clock;

    food_controller dut (
        .clock      (clock),
        .reset      (reset),
        .run        (run),
        .head_x     (head_x),
        .head_y     (head_y),
        .food_x     (food_x),
        .food_y     (food_y),
        .food_valid (food_valid),
        .eat        (eat),
        .length     (length),
        .score      (score)
    );

    // A box this large can never fit on screen, so every candidate fails.
    food_controller #(.FOOD_SIZE(500)) dut_fb (
        .clock      (clock),
        .reset      (reset),
        .run        (run),
        .head_x     (head2_x),
        .head_y     (head2_y),
        .food_x     (food2_x),
        .food_y     (food2_y),
        .food_valid (food2_valid),
        .eat        (eat2),
        .length     (length2),
        .score      (score2)
    );

    function automatic bit box_hits_wall(input int x, input int y, input int s);
        for (int i = 0; i < 21; i++)
            if (x <= walls[i][1] && x + s > walls[i][0] && y <= walls[i][3] && y + s > walls[i][2])
                return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        head_x = 0; head_y = 0; head2_x = 0; head2_y = 0;
        run = 1'b1;
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        // Reset state
        chk("rst_food_x", food_x, 300);
        chk("rst_food_y", food_y, 100);
        chk("rst_valid", food_valid, 1);
        chk("rst_length", length, 2);
        chk("rst_score", score, 0);
        chk("rst_eat", eat, 0);
        chk("rst_fb_valid", food2_valid, 1);

        // Fallback: every candidate invalid, so exactly 8 PLACE cycles then (300,100)
        head2_x = 303; head2_y = 105;
        @(negedge clock);
        chk("fb_eat", eat2, 1);
        chk("fb_valid_low", food2_valid, 0);
        chk("fb_length", length2, 3);
        head2_x = 0; head2_y = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            chk("fb_pending", food2_valid, 0);
        end
        @(negedge clock);
        chk("fb_valid", food2_valid, 1);
        chk("fb_food_x", food2_x, 300);
        chk("fb_food_y", food2_y, 100);
        chk("fb_eat_low", eat2, 0);
        chk("fb_score", score2, 1);

        // First eat on the reset food
        head_x = 303; head_y = 105;
        @(negedge clock);
        chk("eat1_pulse", eat, 1);
        chk("eat1_length", length, 3);
        chk("eat1_score", score, 1);
        chk("eat1_valid_low", food_valid, 0);
        @(negedge clock);
        chk("eat1_one_cycle", eat, 0);
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (food_valid) begin
                found = 1'b1;
                break;
            end
        end
        chk("place_within_8", found, 1);
        chk("place_in_bounds", int'(food_x + 10 <= 640 && food_y + 10 <= 480), 1);
        chk("place_off_walls", box_hits_wall(food_x, food_y, 10), 0);

        // Repeated eats up to and past length saturation
        score_exp = 1;
        len_exp   = 3;
        for (int k = 0; k < 99; k++) begin
            found = 1'b0;
            for (int i = 0; i < 12; i++) begin
                if (food_valid) begin
                    found = 1'b1;
                    break;
                end
                @(negedge clock);
            end
            chk("sat_food_ready", found, 1);
            head_x = food_x + 10'd1;
            head_y = food_y + 10'd1;
            @(negedge clock);
            score_exp++;
            len_exp = (len_exp + 1 > 99) ? 99 : len_exp + 1;
            chk("sat_eat", eat, 1);
            if (score_exp == 97) begin
                chk("len_at_97", length, 99);
                chk("score_at_97", score, 97);
            end
        end
        chk("sat_length", length, len_exp);
        chk("sat_length_99", length, 99);
        chk("sat_score", score, 100);

        // run=0 holds off the eat while the head sits on the food
        found = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (food_valid) begin
                found = 1'b1;
                break;
            end
            @(negedge clock);
        end
        chk("run_food_ready", found, 1);
        run = 1'b0;
        head_x = food_x + 10'd2;
        head_y = food_y + 10'd2;
        repeat (3) begin
            @(negedge clock);
            chk("run0_no_eat", eat, 0);
            chk("run0_valid", food_valid, 1);
        end
        run = 1'b1;
        @(negedge clock);
        chk("run1_eat", eat, 1);
        chk("run1_score", score, 101);
        chk("run1_length", length, 99);

        // Asynchronous reset while placing
        @(negedge clock);
        chk("pre_rst_placing", food_valid, 0);
        chk("pre_rst_eat", eat, 0);
        #2 reset = 1'b0;
        #1;
        chk("arst_food_x", food_x, 300);
        chk("arst_food_y", food_y, 100);
        chk("arst_valid", food_valid, 1);
        chk("arst_length", length, 2);
        chk("arst_score", score, 0);
        chk("arst_eat", eat, 0);
        @(negedge clock);
        reset = 1'b1;
        head_x = 303; head_y = 105;
        @(negedge clock);
        chk("post_rst_eat", eat, 1);
        chk("post_rst_length", length, 3);
        chk("post_rst_score", score, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
